// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and default timing constants for uart_tx.
// Defining UART_TX_PARITY_EN adds the PARITY state (even parity bit).
package uart_pkg;

  localparam int unsigned DEF_CLOCK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD       = 115_200;
  localparam int unsigned DEF_STOP_BITS  = 2;
  localparam int unsigned CNT_W          = 20;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART transmitter.
// bit_tick marks the last cycle of each bit; restart holds the count at 0.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLOCK_FREQ / DEF_BAUD
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == LAST) && !restart;

  // count cycles within a bit, wrapping at the bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
// UART_TX_PARITY_EN inserts an even parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEF_CLOCK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD;

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic       bit_tick;
  logic       line;
  logic       last_stop;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  assign tx_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign last_stop = (STOP_BITS < 2) || stop_cnt;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (tx_ready),
    .bit_tick(bit_tick)
  );

  // line level implied by the current state
  always_comb begin
    line = 1'b1;
    unique case (state)
      START:   line = 1'b0;
      DATA:    line = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line = par;
`endif
      default: line = 1'b1;
    endcase
  end

  // frame sequencer with registered txd and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      txd  <= line;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= even_par(tx_data);
`endif
            state    <= START;
          end
        end
        START: begin
          if (bit_tick) state <= DATA;
        end
        DATA: begin
          if (bit_tick) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) state <= STOP;
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (last_stop) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at default rate
// and at 9600 baud with one stop bit.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB_A  = 434;
  localparam int CPB_B  = 5208;
  localparam int STOP_A = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_A = CPB_A * (11 + PBITS);
  localparam int FRAME_B = CPB_B * (10 + PBITS);

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   b_fin = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a = 1'b1;
  logic [7:0] tx_data_a = '0;
  logic       tx_valid_a = 1'b0;
  logic       tx_ready_a, txd_a, busy_a, done_a;

  logic       rst_b = 1'b1;
  logic [7:0] tx_data_b = '0;
  logic       tx_valid_b = 1'b0;
  logic       tx_ready_b, txd_b, busy_b, done_b;

  uart_tx u_a (
    .clk     (clk),
    .rst     (rst_a),
    .tx_data (tx_data_a),
    .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a),
    .txd     (txd_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  uart_tx #(
    .BAUD     (9600),
    .STOP_BITS(1)
  ) u_b (
    .clk     (clk),
    .rst     (rst_b),
    .tx_data (tx_data_b),
    .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b),
    .txd     (txd_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  int   done_cnt_a = 0, last_done_a = 0, last_start_a = 0;
  int   done_cnt_b = 0, last_done_b = 0;
  logic prev_txd_a = 1'b1;

  always @(posedge clk) begin
    prev_txd_a <= txd_a;
    if (done_a === 1'b1) begin
      done_cnt_a  <= done_cnt_a + 1;
      last_done_a <= cyc;
    end
    if (prev_txd_a === 1'b1 && txd_a === 1'b0) last_start_a <= cyc;
    if (done_b === 1'b1) begin
      done_cnt_b  <= done_cnt_b + 1;
      last_done_b <= cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bit_win(input bit first, output logic v,
                         inout bit ok, inout bit ab);
    logic f;
    if (!first) @(negedge clk);
    f = txd_a;
    v = f;
    if (rst_a) begin ab = 1; return; end
    for (int k = 1; k < CPB_A; k++) begin
      @(negedge clk);
      if (rst_a) begin ab = 1; return; end
    end
    v = txd_a;
    if (f !== v) ok = 0;
  endtask

  initial begin : mon_a
    exp_t       e;
    logic [7:0] d;
    logic       v, p;
    bit         ok, ab;
    forever begin
      @(negedge clk);
      if (rst_a || txd_a !== 1'b0) continue;
      ok = 1; ab = 0; d = '0; p = 1'b0;
      bit_win(1, v, ok, ab);
      if (v !== 1'b0) ok = 0;
      for (int i = 0; i < 8; i++) begin
        if (!ab) begin
          bit_win(0, v, ok, ab);
          d[i] = v;
        end
      end
`ifdef UART_TX_PARITY_EN
      if (!ab) bit_win(0, p, ok, ab);
`endif
      for (int i = 0; i < STOP_A; i++) begin
        if (!ab) begin
          bit_win(0, v, ok, ab);
          if (v !== 1'b1) ok = 0;
        end
      end
      if (ab) begin
        while (rst_a) @(negedge clk);
        continue;
      end
      chk("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("frame_data", d, e.d);
        chk("framing", ok, 1);
`ifdef UART_TX_PARITY_EN
        chk("parity", p, e.p);
`endif
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input bit push,
                      input bit hold, output int acc);
    int g;
    g = 0;
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    if (push) sb.push_back('{d, p});
    while (!tx_ready_a && g < 3 * FRAME_A) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", tx_ready_a, 1);
    @(negedge clk);
    acc = cyc;
    if (!hold) tx_valid_a = 1'b0;
  endtask

  task automatic wait_done(input int acc, input int n0, input string nm);
    int g;
    g = 0;
    while (done_cnt_a == n0 && g < FRAME_A + 1000) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_done_dly"}, last_done_a - acc, FRAME_A);
    repeat (3) @(negedge clk);
    chk({nm, "_done_cnt"}, done_cnt_a - n0, 1);
  endtask

  initial begin : stim_a
    int acc, acc2, n0, g, hi;
    repeat (4) @(negedge clk);
    chk("rst_txd", txd_a, 1);
    chk("rst_ready", tx_ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);

    n0 = done_cnt_a;
    send(8'h55, 1'b0, 1, 0, acc);
    wait_done(acc, n0, "f55");
    n0 = done_cnt_a;
    send(8'h07, 1'b1, 1, 0, acc);
    wait_done(acc, n0, "f07");
    n0 = done_cnt_a;
    send(8'h03, 1'b0, 1, 0, acc);
    wait_done(acc, n0, "f03");

    n0 = done_cnt_a;
    send(8'hA5, 1'b0, 1, 1, acc);
    tx_data_a = 8'h3C;
    send(8'h3C, 1'b0, 1, 0, acc2);
    chk("held_accept_gap", acc2 - acc, FRAME_A + 1);
    repeat (3) @(negedge clk);
    chk("held_start_gap", last_start_a - last_done_a, 2);
    wait_done(acc2, n0 + 1, "f3c");

    n0 = done_cnt_a;
    send(8'h00, 1'b0, 1, 0, acc);
    hi = 0;
    g  = 0;
    while (done_cnt_a == n0 && g < FRAME_A + 100) begin
      @(negedge clk);
      g++;
      if (g == 3 * CPB_A) begin
        tx_data_a  = 8'hFF;
        tx_valid_a = 1'b1;
      end else if (g == 3 * CPB_A + 1) begin
        tx_valid_a = 1'b0;
        tx_data_a  = 8'h00;
      end
      if (g < FRAME_A && tx_ready_a) hi++;
    end
    chk("ignore_ready_low", hi, 0);
    wait_done(acc, n0, "f00");

    n0 = done_cnt_a;
    send(8'h81, 1'b0, 0, 0, acc);
    repeat (4 * CPB_A + 200) @(negedge clk);
    chk("pre_abort_txd", txd_a, 0);
    #2 rst_a = 1'b1;
    #1;
    chk("abort_txd", txd_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_ready", tx_ready_a, 1);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) hi++;
    end
    chk("release_glitch", hi, 0);
    chk("release_no_done", done_cnt_a - n0, 0);
    send(8'h81, 1'b0, 1, 0, acc);
    wait_done(acc, n0, "f81");

    g = 0;
    while (!b_fin && g < 80000) begin
      @(negedge clk);
      g++;
    end
    chk("b_finished", b_fin, 1);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : stim_b
    int         acc, n, g;
    logic [7:0] d;
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    tx_data_b  = 8'h55;
    tx_valid_b = 1'b1;
    chk("b_ready", tx_ready_b, 1);
    @(negedge clk);
    acc = cyc;
    tx_valid_b = 1'b0;
    g = 0;
    while (txd_b !== 1'b0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    n = 0;
    while (txd_b === 1'b0 && n < 2 * CPB_B) begin
      @(negedge clk);
      n++;
    end
    chk("b_start_len", n, CPB_B);
    repeat (CPB_B / 2) @(negedge clk);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[i] = txd_b;
      if (i < 7) repeat (CPB_B) @(negedge clk);
    end
    chk("b_data", d, 8'h55);
    g = 0;
    while (done_cnt_b == 0 && g < FRAME_B) begin
      @(negedge clk);
      g++;
    end
    chk("b_frame_len", last_done_b - acc, FRAME_B);
    repeat (50) @(negedge clk);
    chk("b_done_cnt", done_cnt_b, 1);
    b_fin = 1;
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: cycles got 90000 limit 90000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
